xbee_tx_arbiter: RTL
====================

XBEE_TX_ARBITER -- requirements
Module: xbee_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning cycles allowed per wait state before abort.
REQ-002 The block SHALL have port Clk, input, 1, the single system clock, with every register clocked on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports Req0/Req1, input, 1 each, meaning requester n has a byte pending.
REQ-005 The block SHALL have ports Din0/Din1, input, 8 each, meaning requester n byte.
REQ-006 The block SHALL have ports Last0/Last1, input, 1 each, meaning the presented byte ends the frame.
REQ-007 The block SHALL have ports Ack0/Ack1, output, 1 each, meaning a one-cycle pulse when the byte is taken.
REQ-008 The block SHALL have port BusyFlag, input, 1, the transmitter-busy flag from the serial plot coder.
REQ-009 The block SHALL have port ND, output, 1, a one-cycle new-data strobe to the transmitter.
REQ-010 The block SHALL have port Dout, output, 8, the byte to the transmitter, valid while ND=1.
REQ-011 The block SHALL have port Grant, output, 2, meaning one-hot current frame owner, 00 when idle.
REQ-012 The block SHALL have port Error, output, 1, a one-cycle pulse on timeout abort.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-014 In IDLE with one Req high, that requester SHALL be granted and the FSM SHALL go to LOAD next cycle.
REQ-015 In IDLE with both Req high, the requester not served last SHALL be granted (round-robin).
REQ-016 A grant SHALL be frame-atomic: Grant holds from grant until the Last byte completes or abort; the other requester is never interleaved.
REQ-017 In LOAD with Req[owner]=1, the next edge SHALL register Dout<=Din[owner], Last<=Last[owner], assert ND and Ack[owner] for exactly one cycle, and enter WAIT_BUSY.
REQ-018 In LOAD with Req[owner]=0, the FSM SHALL stay in LOAD.
REQ-019 In WAIT_BUSY the FSM SHALL advance to WAIT_DONE on BusyFlag=1.
REQ-020 In WAIT_DONE the FSM SHALL advance on BusyFlag=0: to IDLE with Grant=00 and last-served updated if the latched Last=1, else to LOAD.
REQ-021 ND SHALL never be asserted while BusyFlag=1 or within WAIT_BUSY/WAIT_DONE.
REQ-022 Latency SHALL be Req rise in IDLE to ND = 2 cycles, and BusyFlag fall to next ND in the same frame = 2 cycles if Req held.
REQ-023 Req dropping while not in LOAD SHALL have no effect; requesters hold Din/Last stable until Ack.
REQ-024 Ack0 and Ack1 SHALL never be high together, and Grant SHALL always be one-hot or zero.

Reset
REQ-025 On Reset=1 at an edge, the FSM SHALL go to IDLE and ND, Ack0, Ack1, Error, Grant, Dout and the timeout counter SHALL be set to 0, with last-served=1 so requester 0 wins the first tie.
REQ-026 Reset mid-frame SHALL abandon the frame without an ND or Ack pulse on that cycle.

Configuration
REQ-027 With XBEE_ARB_TIMEOUT_EN defined, a counter SHALL clear on every state entry and count in LOAD (mid-frame only), WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to IDLE, Grant=00, pulse Error one cycle, toggle last-served, and not emit ND or Ack.
REQ-028 Without XBEE_ARB_TIMEOUT_EN, no counter SHALL be built, Error SHALL be tied 0, and wait states SHALL wait indefinitely.

Verification
REQ-029 Req0=1, Din0=0x7E, Last0=1, BusyFlag high 3 cycles after ND -> ND after 2 cycles, Dout=0x7E, Ack0 coincident, Grant=01 until BusyFlag falls, then 00.
REQ-030 Req0 and Req1 rise together after reset, each a 1-byte frame -> requester 0 served first, then requester 1; repeat -> order alternates.
REQ-031 Requester 0 sends 3-byte frame 0x7E,0x00,0x05 while Req1 is held high -> all three bytes precede any Ack1, and Grant stays 01 throughout.
REQ-032 Reset asserted while in WAIT_DONE -> next cycle Grant=00, ND=0, and a new Req1 is served normally.
REQ-033 XBEE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, BusyFlag stuck 0 after ND -> Error pulse 16 cycles after WAIT_BUSY entry, Grant=00, no further ND.
REQ-034 Without the macro, BusyFlag stuck 0 for 1000 cycles -> Error stays 0 and the FSM remains in WAIT_BUSY.

Source files
------------

// File: rtl/xbee_tx_arbiter.sv
// rtl/xbee_tx_arbiter.sv - two-requester frame-atomic byte arbiter feeding a busy-flagged serial transmitter
//
// Purpose:
//   Grants one of two byte requesters ownership of the transmitter for a whole
//   frame (round-robin on ties), hands each byte over with a one-cycle ND
//   strobe and waits for the transmitter's BusyFlag to rise and fall before
//   taking the next byte.
//
// Optional feature (macro XBEE_ARB_TIMEOUT_EN):
//   When defined, a per-state cycle counter aborts the frame if a wait state
//   lasts TIMEOUT_CYCLES cycles, pulsing Error. When undefined, no counter is
//   built, Error is tied low and wait states wait indefinitely.
//
// Ports:
//   Clk             in   system clock, rising edge
//   Reset           in   synchronous active-high reset
//   Req0/Req1       in   requester n has a byte pending
//   Din0/Din1 [7:0] in   requester n byte
//   Last0/Last1     in   presented byte ends the frame
//   Ack0/Ack1       out  one-cycle pulse when requester n's byte is taken
//   BusyFlag        in   transmitter busy
//   ND              out  one-cycle new-data strobe to the transmitter
//   Dout [7:0]      out  byte to the transmitter, valid while ND=1
//   Grant [1:0]     out  one-hot frame owner, 00 when idle
//   Error           out  one-cycle pulse on timeout abort

module xbee_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [7:0] Din0,
  input  logic [7:0] Din1,
  input  logic       Last0,
  input  logic       Last1,
  output logic       Ack0,
  output logic       Ack1,
  input  logic       BusyFlag,
  output logic       ND,
  output logic [7:0] Dout,
  output logic [1:0] Grant,
  output logic       Error
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [1:0] r_grant;
  logic [1:0] w_grant_next;
  logic       r_last_served;   // index of the requester whose frame finished last
  logic       w_last_served_next;
  logic       r_last;          // Last flag of the byte currently in the transmitter
  logic       w_last_next;
  logic [7:0] r_dout;
  logic [7:0] w_dout_next;
  logic       r_nd;
  logic       w_nd_next;
  logic       r_ack0;
  logic       w_ack0_next;
  logic       r_ack1;
  logic       w_ack1_next;

  // Owner's request lines; Grant is one-hot so bit 1 alone selects requester 1.
  logic       w_own_req;
  logic [7:0] w_own_din;
  logic       w_own_last;

  assign w_own_req  = r_grant[1] ? Req1  : Req0;
  assign w_own_din  = r_grant[1] ? Din1  : Din0;
  assign w_own_last = r_grant[1] ? Last1 : Last0;

`ifdef XBEE_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_tmo_cnt;
  logic [CW-1:0] w_tmo_cnt_next;
  logic          r_mid;        // at least one byte of the current frame has been taken
  logic          w_mid_next;
  logic          r_error;
  logic          w_error_next;
  logic          w_counting;
  logic          w_tmo_hit;

  // LOAD only times out once the frame has started; waiting for a first byte is not a stall.
  assign w_counting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE) ||
                      ((r_state == S_LOAD) && r_mid);
  assign w_tmo_hit  = w_counting && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign Error      = r_error;
`else
  assign Error      = 1'b0;
`endif

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_last_served_next = r_last_served;
    w_last_next        = r_last;
    w_dout_next        = r_dout;
    w_nd_next          = 1'b0;
    w_ack0_next        = 1'b0;
    w_ack1_next        = 1'b0;
`ifdef XBEE_ARB_TIMEOUT_EN
    w_mid_next         = r_mid;
    w_error_next       = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (Req0 && Req1) begin
          w_grant_next = r_last_served ? 2'b01 : 2'b10;
          w_state_next = S_LOAD;
        end else if (Req0) begin
          w_grant_next = 2'b01;
          w_state_next = S_LOAD;
        end else if (Req1) begin
          w_grant_next = 2'b10;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_own_req) begin
          w_dout_next  = w_own_din;
          w_last_next  = w_own_last;
          w_nd_next    = 1'b1;
          w_ack0_next  = r_grant[0];
          w_ack1_next  = r_grant[1];
          w_state_next = S_WAIT_BUSY;
`ifdef XBEE_ARB_TIMEOUT_EN
          w_mid_next   = 1'b1;
`endif
        end
      end
      S_WAIT_BUSY: begin
        if (BusyFlag) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!BusyFlag) begin
          if (r_last) begin
            w_state_next       = S_IDLE;
            w_grant_next       = 2'b00;
            w_last_served_next = r_grant[1];
`ifdef XBEE_ARB_TIMEOUT_EN
            w_mid_next         = 1'b0;
`endif
          end else begin
            w_state_next = S_LOAD;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = 2'b00;
      end
    endcase

`ifdef XBEE_ARB_TIMEOUT_EN
    // Abort overrides everything the state logic decided this cycle.
    if (w_tmo_hit) begin
      w_state_next       = S_IDLE;
      w_grant_next       = 2'b00;
      w_nd_next          = 1'b0;
      w_ack0_next        = 1'b0;
      w_ack1_next        = 1'b0;
      w_error_next       = 1'b1;
      w_last_served_next = ~r_last_served;
      w_mid_next         = 1'b0;
    end

    if (w_state_next != r_state) begin
      w_tmo_cnt_next = '0;
    end else if (w_counting) begin
      w_tmo_cnt_next = r_tmo_cnt + 1'b1;
    end else begin
      w_tmo_cnt_next = '0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_last_served <= 1'b1;
      r_last        <= 1'b0;
      r_dout        <= 8'h00;
      r_nd          <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
`ifdef XBEE_ARB_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_mid         <= 1'b0;
      r_error       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_last_served <= w_last_served_next;
      r_last        <= w_last_next;
      r_dout        <= w_dout_next;
      r_nd          <= w_nd_next;
      r_ack0        <= w_ack0_next;
      r_ack1        <= w_ack1_next;
`ifdef XBEE_ARB_TIMEOUT_EN
      r_tmo_cnt     <= w_tmo_cnt_next;
      r_mid         <= w_mid_next;
      r_error       <= w_error_next;
`endif
    end
  end

  assign ND    = r_nd;
  assign Dout  = r_dout;
  assign Ack0  = r_ack0;
  assign Ack1  = r_ack1;
  assign Grant = r_grant;

endmodule
